imul: RTL and testbench
=======================

// Module: imul
// PURPOSE
//   Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU); counterpart of the iterative divider in the integer register stage.
//   Accepts operands at issue, stalls the front end while iterating, pulses mul_last with the 32-bit result for writeback.
//   Same issue/stall/last handshake as the divider, so the pipeline control treats both units identically.
// PARAMETERS
//   XLEN            32  operand/result width
//   BITS_PER_CYCLE  2   multiplier bits retired per iteration; legal 1,2,4; N = XLEN/BITS_PER_CYCLE iterations
// PORTS
//   clk         in   1     clock, all state on posedge
//   reset       in   1     asynchronous, active-high; clears all state
//   mul_start   in   1     issue strobe, one cycle; operands/op/rd sampled on this edge
//   mul_op      in   2     funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   mul_kill    in   1     flush: abort an in-flight multiply, no mul_last
//   rd          in   5     destination register, carried to rd_out
//   rs1_data    in   XLEN  multiplicand (signed for MULH/MULHSU)
//   rs2_data    in   XLEN  multiplier (signed for MULH only)
//   stall_m     out  1     = mul_start | busy; holds issue/decode
//   mul_last    out  1     registered one-cycle pulse: mul_result/rd_out valid
//   mul_result  out  XLEN  MUL: product[31:0]; others: product[63:32]
//   rd_out      out  5     rd captured at start
// BEHAVIOUR
//   Reset: count=0, busy=0, mul_last=0, mul_result=0, rd_out=0, accumulator/operand regs=0.
//   Operand prep at start edge: sign flags s1=rs1[31]&(op==01|op==10), s2=rs2[31]&(op==01);
//     store |rs1|,|rs2| as XLEN-bit unsigned magnitudes (|0x80000000| = 0x80000000, no overflow); neg=s1^s2.
//     acc(2*XLEN) <= 0; count <= 1; rd_out <= rd; op latched.
//   Iteration (busy=count!=0): each edge add mcand*mplier[BPC-1:0] into acc upper half,
//     shift {acc,mplier} right by BPC (carry kept, acc upper needs XLEN+BPC bits internally).
//     count increments; at count==N the edge completes the last step, count<=0.
//   Completion: same edge as count N->0, mul_last<=1 and mul_result<=select(neg ? -P : P) with P the
//     64-bit unsigned product, two's-complement negation over 64 bits. mul_last falls the next edge.
//   Latency: start sampled at edge E0 -> mul_last high in cycle after edge E0+N (N=16 default: E0+16).
//   stall_m high in start cycle and every busy cycle; low in the mul_last cycle.
//   mul_result holds its value until the next completion (or reset); not cleared by start.
//   Boundaries:
//     mul_start while busy: ignored (protocol violation; operands not resampled, no restart).
//     mul_start in the mul_last cycle: accepted normally (back-to-back issue).
//     mul_kill while busy: count<=0, no mul_last, mul_result unchanged. mul_kill with mul_start same edge: kill wins, nothing issued.
//     mul_kill on the completion edge: kill wins, mul_last stays 0.
//     reset mid-operation: immediate clear, no mul_last after release.
//     zero operands: full N iterations, no early exit (fixed latency).
// TESTING
//   MUL 7 * 0xFFFFFFFD -> mul_last exactly 17 cycles after start edge, result 0xFFFFFFEB, rd_out=rd.
//   MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//   MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF; MULHSU 0x00000002 * 0x80000000 -> 0x00000001.
//   Back-to-back: start MUL 3*5 then start MULHU 0xFFFFFFFF*2 in the mul_last cycle -> 15, then 0x00000001; stall_m low only in mul_last cycles.
//   mul_kill at cycle 5 of an op -> no mul_last, stall_m drops next cycle, mul_result keeps prior value.
//   reset asserted at cycle 8 -> all outputs 0 asynchronously; new start after release completes in 17 cycles.

Source files
------------

// File: rtl/imul.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Operands are sampled on the issue edge as unsigned magnitudes. A radix
// 2^BITS_PER_CYCLE shift-add loop then retires BITS_PER_CYCLE multiplier
// bits per clock, and the sign is applied to the 64-bit product on the
// completion edge. The issue/stall/last handshake matches the iterative
// divider, so pipeline control can treat both units the same way.
module imul #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 2   // legal values: 1, 2, 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mul_start,
  input  logic [1:0]      mul_op,
  input  logic            mul_kill,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            stall_m,
  output logic            mul_last,
  output logic [XLEN-1:0] mul_result,
  output logic [4:0]      rd_out
);

  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = XLEN / BPC;
  localparam int CW  = $clog2(N + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(N);

  // Iteration state. The product is assembled across two registers:
  //   r_acc    - upper half (the running partial sum)
  //   r_mplier - holds the unconsumed multiplier bits in its low end, while
  //              the low product bits shift in from the top
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic            r_neg;
  logic            r_is_mul;

  logic            w_busy;
  logic            w_sign1;
  logic            w_sign2;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic [XLEN+BPC-1:0] w_digit;
  logic [XLEN+BPC-1:0] w_pp;
  logic [XLEN+BPC-1:0] w_sum;
  logic [XLEN-1:0]     w_acc_next;
  logic [XLEN-1:0]     w_mplier_next;
  logic [2*XLEN-1:0]   w_product;
  logic [2*XLEN-1:0]   w_signed;
  logic [XLEN-1:0]     w_result;

  assign w_busy  = (r_count != '0);
  assign stall_m = mul_start | w_busy;

  // Operand preparation. The rs1 sign is used only for MULH and MULHSU.
  // The rs2 sign is used only for MULH. A magnitude of 0x80000000 is
  // still correct when it is read as unsigned.
  assign w_sign1 = rs1_data[XLEN-1] & ((mul_op == 2'b01) | (mul_op == 2'b10));
  assign w_sign2 = rs2_data[XLEN-1] & (mul_op == 2'b01);
  assign w_mag1  = w_sign1 ? (~rs1_data + 1'b1) : rs1_data;
  assign w_mag2  = w_sign2 ? (~rs2_data + 1'b1) : rs2_data;

  // One radix-2^BPC step. The partial product needs BPC carry bits above
  // XLEN. After the shift, those carry bits fall back into XLEN.
  assign w_digit       = {{XLEN{1'b0}}, r_mplier[BPC-1:0]};
  assign w_pp          = {{BPC{1'b0}}, r_mcand} * w_digit;
  assign w_sum         = {{BPC{1'b0}}, r_acc} + w_pp;
  assign w_acc_next    = w_sum[XLEN+BPC-1:BPC];
  assign w_mplier_next = {w_sum[BPC-1:0], r_mplier[XLEN-1:BPC]};

  // On the final step this is the complete unsigned product. The sign is
  // applied over all 2*XLEN bits before the result half is selected.
  assign w_product = {w_acc_next, w_mplier_next};
  assign w_signed  = r_neg ? (~w_product + 1'b1) : w_product;
  assign w_result  = r_is_mul ? w_signed[XLEN-1:0] : w_signed[2*XLEN-1:XLEN];

  // Issue, iteration, completion and flush sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_neg      <= 1'b0;
      r_is_mul   <= 1'b0;
      mul_last   <= 1'b0;
      mul_result <= '0;
      rd_out     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge value of r_count/r_acc no matter what order the branches run in.
      mul_last <= 1'b0;
      if (mul_kill) begin
        // A flush beats both an in-flight completion and a same-edge issue.
        r_count <= '0;
      end else if (w_busy) begin
        // A start strobe while busy is ignored.
        r_acc    <= w_acc_next;
        r_mplier <= w_mplier_next;
        if (r_count == LP_LAST) begin
          r_count    <= '0;
          mul_last   <= 1'b1;
          mul_result <= w_result;
        end else begin
          r_count <= r_count + CW'(1);
        end
      end else if (mul_start) begin
        r_count  <= CW'(1);
        r_mcand  <= w_mag1;
        r_mplier <= w_mag2;
        r_acc    <= '0;
        r_neg    <= w_sign1 ^ w_sign2;
        r_is_mul <= (mul_op == 2'b00);
        rd_out   <= rd;
      end
    end
  end

endmodule

// File: tb/tb_imul.sv
// Self-checking bench for imul. A transaction-level model predicts the
// outputs from 64-bit signed arithmetic and a fixed N-edge latency. One
// process compares every output on every falling edge. Directed cases pin
// the model to hand-computed values. A randomized loop covers the rest.
module tb_imul;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        mul_start;
  logic [1:0]  mul_op;
  logic        mul_kill;
  logic [4:0]  rd;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        stall_m;
  logic        mul_last;
  logic [31:0] mul_result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_fail   = 0;

  imul dut (
    .clk       (clk),
    .reset     (reset),
    .mul_start (mul_start),
    .mul_op    (mul_op),
    .mul_kill  (mul_kill),
    .rd        (rd),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .stall_m   (stall_m),
    .mul_last  (mul_last),
    .mul_result(mul_result),
    .rd_out    (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result computed directly from RV32M semantics.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    sa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    sb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = sa * sb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Transaction model: an accepted op completes exactly N edges after issue.
  int          m_left;
  logic        m_last;
  logic [31:0] m_pend, m_res;
  logic [4:0]  m_rd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      m_last <= 1'b0;
      m_pend <= '0;
      m_res  <= '0;
      m_rd   <= '0;
    end else begin
      m_last <= 1'b0;
      if (mul_kill) begin
        m_left <= 0;
      end else if (m_left == 1) begin
        m_left <= 0;
        m_last <= 1'b1;
        m_res  <= m_pend;
      end else if (m_left > 1) begin
        m_left <= m_left - 1;
      end else if (mul_start) begin
        m_left <= N;
        m_pend <= ref_mul(mul_op, rs1_data, rs2_data);
        m_rd   <= rd;
      end
    end
  end

  // Compare on every falling edge, away from input changes and clock edges.
  always @(negedge clk) begin
    check("mul_last",   {63'b0, mul_last}, {63'b0, m_last});
    check("stall_m",    {63'b0, stall_m},  {63'b0, mul_start | (m_left != 0)});
    check("mul_result", {32'b0, mul_result}, {32'b0, m_res});
    check("rd_out",     {59'b0, rd_out},   {59'b0, m_rd});
  end

  // Caller must be away from a clock edge. Returns at posedge + 1.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r);
    mul_start = 1'b1;
    mul_op    = op;
    rs1_data  = a;
    rs2_data  = b;
    rd        = r;
    @(posedge clk);
    #1;
    mul_start = 1'b0;
    rs1_data  = $urandom;
    rs2_data  = $urandom;
    rd        = 5'($urandom);
  endtask

  // Counts edges from the issue edge (inclusive) until mul_last is seen.
  // Returns at the falling edge of the mul_last cycle, or gives 99 on timeout.
  task automatic wait_last(output int cyc);
    cyc = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mul_last) return;
      @(posedge clk);
      cyc++;
    end
    cyc = 99;
  endtask

  task automatic run_directed(input string name, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] r,
                              input logic [31:0] exp);
    int cyc;
    issue(op, a, b, r);
    wait_last(cyc);
    check({name, " latency"}, 64'(cyc), 64'(N + 1));
    check({name, " result"},  {32'b0, mul_result}, {32'b0, exp});
    check({name, " rd_out"},  {59'b0, rd_out}, {59'b0, r});
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [1:0]  op;
    logic [31:0] a, b;

    reset = 1'b1; mul_start = 1'b0; mul_op = '0; mul_kill = 1'b0;
    rd = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset mul_last",   {63'b0, mul_last}, 64'd0);
    check("reset mul_result", {32'b0, mul_result}, 64'd0);
    check("reset rd_out",     {59'b0, rd_out}, 64'd0);
    check("reset stall_m",    {63'b0, stall_m}, 64'd0);
    #1;

    run_directed("MUL 7*-3",       2'b00, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
    run_directed("MULH min*min",   2'b01, 32'h8000_0000, 32'h8000_0000, 5'd9,  32'h4000_0000);
    run_directed("MULHU max*max",  2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFE);
    run_directed("MULHSU -1*max",  2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFF);
    run_directed("MULHSU 2*2^31",  2'b10, 32'h0000_0002, 32'h8000_0000, 5'd2,  32'h0000_0001);
    run_directed("MULH zero",      2'b01, 32'd0,        32'd0,         5'd3,  32'd0);

    // Back-to-back: the second issue happens in the mul_last cycle of the first.
    issue(2'b00, 32'd3, 32'd5, 5'd10);
    wait_last(cyc);
    check("b2b first latency", 64'(cyc), 64'(N + 1));
    check("b2b first result", {32'b0, mul_result}, 64'd15);
    #1;
    run_directed("b2b MULHU", 2'b11, 32'hFFFF_FFFF, 32'd2, 5'd11, 32'h0000_0001);

    // Kill at cycle 5: no completion, result holds 1.
    issue(2'b00, 32'd100, 32'd100, 5'd12);
    repeat (4) @(posedge clk);
    #1 mul_kill = 1'b1;
    @(posedge clk);
    #1 mul_kill = 1'b0;
    @(negedge clk);
    check("kill stall drop", {63'b0, stall_m}, 64'd0);
    repeat (25) @(negedge clk);
    check("kill result held", {32'b0, mul_result}, 64'd1);
    #1;

    // Kill on the same edge as a start: nothing is issued.
    mul_kill = 1'b1;
    issue(2'b00, 32'd4, 32'd4, 5'd13);
    mul_kill = 1'b0;
    @(negedge clk);
    check("kill+start no busy", {63'b0, stall_m}, 64'd0);
    #1;

    // Kill on the completion edge: mul_last stays low.
    issue(2'b00, 32'd6, 32'd6, 5'd14);
    repeat (N - 1) @(posedge clk);
    #1 mul_kill = 1'b1;
    @(posedge clk);
    #1 mul_kill = 1'b0;
    @(negedge clk);
    check("kill at completion", {63'b0, mul_last}, 64'd0);
    check("kill at completion result", {32'b0, mul_result}, 64'd1);
    #1;

    // A start while busy is ignored: the original operands complete on time.
    issue(2'b00, 32'd9, 32'd11, 5'd15);
    repeat (2) @(posedge clk);
    #1;
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16);
    wait_last(cyc);
    check("start-while-busy latency", 64'(cyc), 64'(N + 1 - 3));
    check("start-while-busy result", {32'b0, mul_result}, 64'd99);
    check("start-while-busy rd", {59'b0, rd_out}, 64'd15);
    #1;

    // Reset at cycle 8: outputs clear asynchronously, and there is no
    // completion afterwards.
    issue(2'b00, 32'd21, 32'd2, 5'd17);
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async reset mul_result", {32'b0, mul_result}, 64'd0);
    check("async reset rd_out", {59'b0, rd_out}, 64'd0);
    check("async reset stall_m", {63'b0, stall_m}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    run_directed("after reset", 2'b00, 32'd21, 32'd2, 5'd18, 32'd42);

    // Randomized traffic: mixed ops, corner operands, occasional kills and
    // back-to-back issue.
    for (int t = 0; t < 150; t++) begin
      op = 2'($urandom);
      case ($urandom_range(5))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'd0;
        default: a = $urandom;
      endcase
      case ($urandom_range(5))
        0: b = 32'h8000_0000;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'd1;
        default: b = $urandom;
      endcase
      issue(op, a, b, 5'($urandom));
      if ($urandom_range(9) == 0) begin
        repeat ($urandom_range(1, 15)) @(posedge clk);
        #1 mul_kill = 1'b1;
        @(posedge clk);
        #1 mul_kill = 1'b0;
      end else begin
        wait_last(cyc);
        check("random latency", 64'(cyc), 64'(N + 1));
        check("random result", {32'b0, mul_result}, {32'b0, ref_mul(op, a, b)});
        #1;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
